ifetch_unit: RTL

- Instruction-fetch reader for the pipelined RV32 core. It consumes the PC register's current value, issues a read to instruction memory over a valid/ready request channel, and takes the response.
- Registers the fetched instruction and its PC toward the IF/ID boundary.
- Drives the PC register's Stall input, so the PC advances exactly once per instruction delivered.
- Handles decode back-pressure, branch flush and misaligned PCs.

---
 rtl/ifetch_unit_if.sv | 27 ++
 rtl/ifetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and imem.
// Request is a valid/ready handshake; the response is a single-cycle valid pulse.
interface ifetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req_valid;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_req_ready;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch reader: issues one imem read per PC value, registers the
// fetched word toward IF/ID, and holds the PC until each entry is accepted.
//
// state  | meaning
// IDLE   | one settle cycle after reset
// REQ    | request imem at pc (or raise a misalign fault entry)
// WAIT   | request accepted, waiting for the response
// HOLD   | entry parked in skid, waiting for the output register to free up
// DROP   | redirect happened with a read in flight; discard its response
module ifetch_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  input  logic             decode_stall,
  input  logic             flush,
  output logic             pc_stall,
  ifetch_unit_if.master    imem,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic             if_misalign
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t           state_q, state_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic             if_mis_q, if_mis_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic             skid_mis_q, skid_mis_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;

  logic             aligned;
  logic             out_free;
  logic             req_valid;
  logic             hs;
  logic             entry_arrive;
  logic [31:0]      entry_instr;
  logic [WIDTH-1:0] entry_pc;
  logic             entry_mis;

  assign aligned   = (pc[1:0] == 2'b00);
  assign out_free  = !if_valid_q || !decode_stall;
  assign req_valid = (state_q == S_REQ) && aligned;
  assign hs        = req_valid && imem.imem_req_ready;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc;

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_misalign = if_mis_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      // DROP only while a read is still outstanding after this edge; a response
      // arriving in the flush cycle retires the outstanding read itself.
      if ((state_q == S_REQ && hs) ||
          ((state_q == S_WAIT || state_q == S_DROP) && !imem.imem_rsp_valid))
        state_d = S_DROP;
      else
        state_d = S_REQ;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (aligned && hs)              state_d = S_WAIT;
          else if (!aligned && !out_free) state_d = S_HOLD;
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) state_d = out_free ? S_REQ : S_HOLD;
        end
        S_HOLD: begin
          if (out_free) state_d = S_REQ;
        end
        S_DROP: begin
          if (imem.imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: entry acceptance, output/skid loading and PC hold.
  always_comb begin
    entry_arrive = !flush &&
                   ((state_q == S_REQ && !aligned) ||
                    (state_q == S_WAIT && imem.imem_rsp_valid));
    entry_instr  = (state_q == S_WAIT) ? imem.imem_rsp_data : NOP_INSTR;
    entry_pc     = (state_q == S_WAIT) ? req_pc_q : pc;
    entry_mis    = (state_q != S_WAIT);

    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_mis_d     = if_mis_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_mis_d   = skid_mis_q;
    req_pc_d     = hs ? pc : req_pc_q;

    if (if_valid_q && !decode_stall) if_valid_d = 1'b0;

    if (flush) begin
      if_valid_d   = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      skid_mis_d   = 1'b0;
    end else if (entry_arrive) begin
      if (out_free) begin
        if_valid_d = 1'b1;
        if_instr_d = entry_instr;
        if_pc_d    = entry_pc;
        if_mis_d   = entry_mis;
      end else begin
        skid_instr_d = entry_instr;
        skid_pc_d    = entry_pc;
        skid_mis_d   = entry_mis;
      end
    end else if (state_q == S_HOLD && out_free) begin
      if_valid_d = 1'b1;
      if_instr_d = skid_instr_q;
      if_pc_d    = skid_pc_q;
      if_mis_d   = skid_mis_q;
    end

    // Reset holds the PC regardless of what flush is doing.
    pc_stall = !(rst_n && (entry_arrive || flush));
  end

  // Output, skid and request-PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_mis_q     <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_mis_q   <= 1'b0;
      req_pc_q     <= '0;
    end else begin
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_mis_q     <= if_mis_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_mis_q   <= skid_mis_d;
      req_pc_q     <= req_pc_d;
    end
  end

endmodule
